// File: rtl/dot_pkg.sv
// Shared types and width helpers for the dot-product engine.
package dot_pkg;

   // Controller states, 3-bit encoding
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR_A = 3'd1,
      WAIT_A = 3'd2,
      ADDR_B = 3'd3,
      WAIT_B = 3'd4,
      ACCUM  = 3'd5,
      DONE   = 3'd6
   } state_t;

   // Width of a length field able to hold 0..vec_len
   function automatic int calc_len_w(input int vec_len);
      return $clog2(vec_len + 1);
   endfunction

   // Accumulator width: full product plus enough headroom for vec_len terms
   function automatic int calc_acc_w(input int data_w, input int vec_len);
      return 2 * data_w + $clog2(vec_len);
   endfunction

endpackage

// File: rtl/dot_mac_unit.sv
// Combinational multiply-accumulate: acc_out = acc_in + ext(a) * ext(b).
// ext() sign-extends in signed mode, zero-extends otherwise; all ACC_W wide.
module dot_mac_unit #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 19
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              signed_mode,
   input  logic [ACC_W-1:0]  acc_in,
   output logic [ACC_W-1:0]  acc_out
);

   logic [ACC_W-1:0] a_ext;
   logic [ACC_W-1:0] b_ext;

   // Extend operands, then multiply modulo 2^ACC_W (exact for two's complement)
   always_comb begin
      a_ext   = {{(ACC_W-DATA_W){signed_mode & a[DATA_W-1]}}, a};
      b_ext   = {{(ACC_W-DATA_W){signed_mode & b[DATA_W-1]}}, b};
      acc_out = acc_in + a_ext * b_ext;
   end

endmodule

// File: rtl/dot_product_engine_p.sv
// Dot-product engine: fetches A[i] and B[i] from a shared read memory one
// element at a time and accumulates their product at full precision.
//
// Handshake: start is sampled only while busy is low; the operation then runs
// with busy high until a one-cycle done pulse, in which result becomes valid
// and stays held until the next completion. abort drops an operation
// (no done, result unchanged); start while busy is ignored.
module dot_product_engine_p
   import dot_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int VEC_LEN = 8,
   parameter int ADDR_W  = 5,
   parameter int MEM_LAT = 2,
   parameter int LEN_W   = calc_len_w(VEC_LEN),
   parameter int ACC_W   = calc_acc_w(DATA_W, VEC_LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              signed_mode,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] base_a,
   input  logic [ADDR_W-1:0] base_b,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   output logic              busy,
   output logic              done,
   output logic [ACC_W-1:0]  result,
   output state_t            dbg_state
);

   localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   state_t              state;
   logic                sm_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    idx_q;
   logic [ADDR_W-1:0]   base_a_q;
   logic [ADDR_W-1:0]   base_b_q;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [DATA_W-1:0]   op_a;
   logic [DATA_W-1:0]   op_b;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    acc_next;
   logic [LEN_W-1:0]    len_clamped;
   logic                wait_last;
   logic                idx_last;

   // Requested lengths beyond the vector capacity are clamped
   assign len_clamped = (len > LEN_W'(VEC_LEN)) ? LEN_W'(VEC_LEN) : len;
   assign wait_last   = (wait_cnt == WAIT_W'(MEM_LAT - 1));
   assign idx_last    = ((idx_q + LEN_W'(1)) == len_q);
   assign busy        = (state != IDLE);
   assign dbg_state   = state;

   dot_mac_unit #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .a           (op_a),
      .b           (op_b),
      .signed_mode (sm_q),
      .acc_in      (acc),
      .acc_out     (acc_next)
   );

   // Controller: sequences the A/B fetches, accumulation and completion pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         mem_addr <= '0;
         mem_rd   <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         acc      <= '0;
         idx_q    <= '0;
         wait_cnt <= '0;
         op_a     <= '0;
         op_b     <= '0;
         sm_q     <= 1'b0;
         len_q    <= '0;
         base_a_q <= '0;
         base_b_q <= '0;
      end else begin
         done <= 1'b0;
         if (state != IDLE && abort) begin
            state  <= IDLE;
            mem_rd <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     sm_q     <= signed_mode;
                     len_q    <= len_clamped;
                     base_a_q <= base_a;
                     base_b_q <= base_b;
                     acc      <= '0;
                     idx_q    <= '0;
                     if (len_clamped == '0) begin
                        result <= '0;
                        done   <= 1'b1;
                        state  <= DONE;
                     end else begin
                        state  <= ADDR_A;
                     end
                  end
               end
               ADDR_A: begin
                  mem_addr <= base_a_q + ADDR_W'(idx_q);
                  mem_rd   <= 1'b1;
                  wait_cnt <= '0;
                  state    <= WAIT_A;
               end
               WAIT_A: begin
                  mem_rd <= 1'b0;
                  if (wait_last) begin
                     op_a  <= mem_rdata;
                     state <= ADDR_B;
                  end else begin
                     wait_cnt <= wait_cnt + WAIT_W'(1);
                  end
               end
               ADDR_B: begin
                  mem_addr <= base_b_q + ADDR_W'(idx_q);
                  mem_rd   <= 1'b1;
                  wait_cnt <= '0;
                  state    <= WAIT_B;
               end
               WAIT_B: begin
                  mem_rd <= 1'b0;
                  if (wait_last) begin
                     op_b  <= mem_rdata;
                     state <= ACCUM;
                  end else begin
                     wait_cnt <= wait_cnt + WAIT_W'(1);
                  end
               end
               ACCUM: begin
                  acc <= acc_next;
                  if (idx_last) begin
                     result <= acc_next;
                     done   <= 1'b1;
                     state  <= DONE;
                  end else begin
                     idx_q <= idx_q + LEN_W'(1);
                     state <= ADDR_A;
                  end
               end
               DONE: begin
                  state <= IDLE;
               end
               default: begin
                  state  <= IDLE;
                  mem_rd <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
